// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-port, fixed-latency memory between the
//                instruction-fetch port (read-only) and the data port
//                (read/write) of a multicycle CPU. Accesses are serialised,
//                the memory latency is counted, read data is registered
//                into the owning port and a one-cycle acknowledge is pulsed.
//
//  Parameters  : AW  - address width
//                DW  - data width
//                LAT - memory access latency in cycles (>= 1); m_rdata is
//                      valid in the LAT-th cycle of the access
//
//  Ports       : CLK, Reset            clock / synchronous active-high reset
//                i_req, i_addr         instruction read request (held to ack)
//                i_ack, i_rdata        instruction completion pulse / word
//                d_req, d_we, d_addr,
//                d_wdata               data request (held to ack)
//                d_ack, d_rdata        data completion pulse / load data
//                m_en, m_we, m_addr,
//                m_wdata, m_rdata      memory-side port
//                busy                  controller is not idle
//
//  Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int LAT = 2
) (
    input  logic          CLK,
    input  logic          Reset,
    // instruction-fetch port
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    // data port
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    // memory port
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    // status
    output logic          busy
);

    // Counter only needs to hold LAT-1; keep at least one bit for LAT = 1.
    localparam int              c_CW       = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [c_CW-1:0] c_CNT_LOAD = c_CW'(LAT - 1);
    localparam logic            c_PORT_I   = 1'b0;
    localparam logic            c_PORT_D   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t          r_state_q,  w_state_d;
    logic [c_CW-1:0] r_cnt_q,    w_cnt_d;
    // last_grant doubles as the owner of the access in flight: it is
    // updated on every grant and only read back while not idle.
    logic            r_last_q,   w_last_d;
    logic            r_we_q,     w_we_d;
    logic [AW-1:0]   r_addr_q,   w_addr_d;
    logic [DW-1:0]   r_wdata_q,  w_wdata_d;
    logic [DW-1:0]   r_irdata_q, w_irdata_d;
    logic [DW-1:0]   r_drdata_q, w_drdata_d;
    logic            w_gnt;

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d  = r_state_q;
        w_cnt_d    = r_cnt_q;
        w_last_d   = r_last_q;
        w_we_d     = r_we_q;
        w_addr_d   = r_addr_q;
        w_wdata_d  = r_wdata_q;
        w_irdata_d = r_irdata_q;
        w_drdata_d = r_drdata_q;
        w_gnt      = c_PORT_I;

        case (r_state_q)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    // Single requester wins outright; on a conflict the
                    // port that was not served last time wins.
                    if (i_req && d_req) begin
                        w_gnt = ~r_last_q;
                    end else begin
                        w_gnt = d_req ? c_PORT_D : c_PORT_I;
                    end
                    w_last_d  = w_gnt;
                    w_cnt_d   = c_CNT_LOAD;
                    w_state_d = ST_ACCESS;
                    if (w_gnt == c_PORT_D) begin
                        w_addr_d  = d_addr;
                        w_we_d    = d_we;
                        w_wdata_d = d_wdata;
                    end else begin
                        // Fetches never write; wdata keeps its old value.
                        w_addr_d  = i_addr;
                        w_we_d    = 1'b0;
                    end
                end
            end

            ST_ACCESS: begin
                if (r_cnt_q == '0) begin
                    // m_rdata is valid only in this final access cycle.
                    if (!r_we_q) begin
                        if (r_last_q == c_PORT_D) begin
                            w_drdata_d = m_rdata;
                        end else begin
                            w_irdata_d = m_rdata;
                        end
                    end
                    w_state_d = ST_RESP;
                end else begin
                    w_cnt_d = r_cnt_q - 1'b1;
                end
            end

            ST_RESP: begin
                w_state_d = ST_IDLE;
            end

            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state_q  <= ST_IDLE;
            r_cnt_q    <= '0;
            r_last_q   <= c_PORT_I;
            r_we_q     <= 1'b0;
            r_addr_q   <= '0;
            r_wdata_q  <= '0;
            r_irdata_q <= '0;
            r_drdata_q <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_cnt_q    <= w_cnt_d;
            r_last_q   <= w_last_d;
            r_we_q     <= w_we_d;
            r_addr_q   <= w_addr_d;
            r_wdata_q  <= w_wdata_d;
            r_irdata_q <= w_irdata_d;
            r_drdata_q <= w_drdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign m_en    = (r_state_q == ST_ACCESS);
    assign m_we    = (r_state_q == ST_ACCESS) && r_we_q;
    assign m_addr  = r_addr_q;
    assign m_wdata = r_wdata_q;

    assign i_ack   = (r_state_q == ST_RESP) && (r_last_q == c_PORT_I);
    assign d_ack   = (r_state_q == ST_RESP) && (r_last_q == c_PORT_D);
    assign i_rdata = r_irdata_q;
    assign d_rdata = r_drdata_q;

    assign busy    = (r_state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter. Drives a LAT=2
//                instance through a directed transaction table, multi-cycle
//                corner sequences and a randomized run against a
//                transaction-level reference model; a LAT=1 instance covers
//                the minimum-latency build.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- LAT=2 instance ----------------
    logic          Reset;
    logic          i_req, d_req, d_we;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic          i_ack, d_ack, m_en, m_we, busy;
    logic [DW-1:0] i_rdata, d_rdata, m_wdata, m_rdata;
    logic [AW-1:0] m_addr;

    mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(LAT)) u_dut (
        .CLK(CLK), .Reset(Reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .busy(busy)
    );

    // Memory model: data only valid in the LAT-th enabled cycle,
    // writes commit at the end of that cycle.
    logic [DW-1:0] mem [0:255];
    logic          mem_init;
    int            en_cnt = 0;

    function automatic logic [DW-1:0] init_val(input int k);
        if (k == 1) return 32'h8C010008;
        return 32'hA5000000 ^ (32'(k) * 32'h01010101);
    endfunction

    always @(posedge CLK) begin
        en_cnt <= m_en ? en_cnt + 1 : 0;
        if (mem_init) begin
            for (int k = 0; k < 256; k++) mem[k] <= init_val(k);
        end else if (m_en && m_we && en_cnt == LAT - 1) begin
            mem[m_addr[9:2]] <= m_wdata;
        end
    end

    assign m_rdata = (m_en && !m_we && en_cnt == LAT - 1) ? mem[m_addr[9:2]]
                                                         : 32'hBAD0BAD0;

    // ---------------- LAT=1 instance ----------------
    logic          i_req1, d_req1, d_we1;
    logic [AW-1:0] i_addr1, d_addr1;
    logic [DW-1:0] d_wdata1;
    logic          i_ack1, d_ack1, m_en1, m_we1, busy1;
    logic [DW-1:0] i_rdata1, d_rdata1, m_wdata1, m_rdata1;
    logic [AW-1:0] m_addr1;

    mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(1)) u_dut1 (
        .CLK(CLK), .Reset(Reset),
        .i_req(i_req1), .i_addr(i_addr1), .i_ack(i_ack1), .i_rdata(i_rdata1),
        .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_ack(d_ack1), .d_rdata(d_rdata1),
        .m_en(m_en1), .m_we(m_we1), .m_addr(m_addr1), .m_wdata(m_wdata1),
        .m_rdata(m_rdata1), .busy(busy1)
    );

    assign m_rdata1 = (m_en1 && !m_we1 && m_addr1 == 32'h20) ? 32'h00000055
                                                             : 32'hBAD0BAD0;

    // ---------------- checking helpers ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } txn_t;

    txn_t          tbl [7];
    logic [DW-1:0] exp_ir, exp_dr;

    // One isolated transaction from an idle DUT, cycle-by-cycle checked.
    task automatic run_txn(input txn_t t);
        if (t.is_d) begin
            d_req = 1'b1; d_we = t.we; d_addr = t.addr; d_wdata = t.wdata;
        end else begin
            i_req = 1'b1; i_addr = t.addr;
        end
        chk("idle_busy", {31'd0, busy}, 32'd0);
        for (int k = 1; k <= LAT; k++) begin
            tick();
            chk("acc_m_en", {31'd0, m_en}, 32'd1);
            chk("acc_m_we", {31'd0, m_we}, {31'd0, t.we});
            chk("acc_m_addr", m_addr, t.addr);
            if (t.we) chk("acc_m_wdata", m_wdata, t.wdata);
            chk("acc_acks", {30'd0, i_ack, d_ack}, 32'd0);
        end
        tick();
        chk("resp_m_en", {31'd0, m_en}, 32'd0);
        chk("resp_i_ack", {31'd0, i_ack}, {31'd0, ~t.is_d});
        chk("resp_d_ack", {31'd0, d_ack}, {31'd0, t.is_d});
        chk("resp_busy", {31'd0, busy}, 32'd1);
        if (!t.we) begin
            if (t.is_d) exp_dr = t.exp_rdata;
            else        exp_ir = t.exp_rdata;
        end
        chk("resp_i_rdata", i_rdata, exp_ir);
        chk("resp_d_rdata", d_rdata, exp_dr);
        if (t.we) chk("mem_written", mem[t.addr[9:2]], t.wdata);
        i_req = 1'b0;
        d_req = 1'b0;
        tick();
        chk("post_busy", {31'd0, busy}, 32'd0);
        chk("post_acks", {30'd0, i_ack, d_ack}, 32'd0);
    endtask

    // ---------------- reference-model state ----------------
    logic [DW-1:0] ref_mem [0:15];

    initial begin
        int            i_cyc, d_cyc;
        logic          i_pend, d_pend, rm_last, rm_owner, rm_we;
        int            rm_grant, rm_ack, rm_free;
        logic [DW-1:0] rm_rd, e_ir, e_dr;

        Reset = 1'b1; mem_init = 1'b1;
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        i_req1 = 0; i_addr1 = 0; d_req1 = 0; d_we1 = 0; d_addr1 = 0; d_wdata1 = 0;
        exp_ir = '0; exp_dr = '0;
        tick();
        tick();

        // Reset state
        chk("rst_busy",    {31'd0, busy}, 32'd0);
        chk("rst_m_en",    {31'd0, m_en}, 32'd0);
        chk("rst_m_we",    {31'd0, m_we}, 32'd0);
        chk("rst_acks",    {30'd0, i_ack, d_ack}, 32'd0);
        chk("rst_i_rdata", i_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_m_addr",  m_addr, 32'd0);
        chk("rst_m_wdata", m_wdata, 32'd0);
        mem_init = 1'b0;
        Reset    = 1'b0;

        // ---------------- directed transaction table ----------------
        tbl[0] = '{1'b0, 1'b0, 32'h00000004, 32'h0,          32'h8C010008};
        tbl[1] = '{1'b1, 1'b1, 32'h00000010, 32'hDEADBEEF,   32'h0};
        tbl[2] = '{1'b1, 1'b0, 32'h00000010, 32'h0,          32'hDEADBEEF};
        tbl[3] = '{1'b0, 1'b0, 32'h00000010, 32'h0,          32'hDEADBEEF};
        tbl[4] = '{1'b1, 1'b0, 32'h00000004, 32'h0,          32'h8C010008};
        tbl[5] = '{1'b1, 1'b1, 32'h00000004, 32'h12345678,   32'h0};
        tbl[6] = '{1'b0, 1'b0, 32'h00000004, 32'h0,          32'h12345678};
        for (int n = 0; n < 7; n++) run_txn(tbl[n]);

        // ---------------- reset in first ACCESS cycle ----------------
        i_req = 1'b1; i_addr = 32'h8;
        tick();
        chk("mid_m_en", {31'd0, m_en}, 32'd1);
        Reset = 1'b1; i_req = 1'b0;
        tick();
        Reset = 1'b0;
        chk("mid_busy",    {31'd0, busy}, 32'd0);
        chk("mid_m_en2",   {31'd0, m_en}, 32'd0);
        chk("mid_i_rdata", i_rdata, 32'd0);
        chk("mid_i_ack",   {31'd0, i_ack}, 32'd0);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4;
        d_cyc = -1; i_cyc = -1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (d_ack && d_cyc < 0) begin d_cyc = c; d_req = 1'b0; end
            if (i_ack) i_cyc = c;
        end
        chk("mid_dack_cycle", 32'(d_cyc), 32'd3);
        chk("mid_no_iack",    32'(i_cyc), 32'hFFFFFFFF);
        chk("mid_d_rdata",    d_rdata, 32'h12345678);

        // ---------------- simultaneous requests after reset ----------------
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        i_req = 1'b1; i_addr = 32'h4;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        i_cyc = -1; d_cyc = -1;
        for (int c = 0; c <= 12; c++) begin
            if (c == 1) chk("conf_m_addr_d", m_addr, 32'h10);
            if (c == 5) chk("conf_m_addr_i", m_addr, 32'h4);
            if (d_ack && d_cyc < 0) begin d_cyc = c; d_req = 1'b0; end
            if (i_ack && i_cyc < 0) begin i_cyc = c; i_req = 1'b0; end
            tick();
        end
        chk("conf_dack_cycle", 32'(d_cyc), 32'd3);
        chk("conf_iack_cycle", 32'(i_cyc), 32'd7);
        chk("conf_d_rdata", d_rdata, 32'hDEADBEEF);
        chk("conf_i_rdata", i_rdata, 32'h12345678);

        // ---------------- continuous contention ----------------
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        i_req = 1'b1; i_addr = 32'h8;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'hC;
        for (int c = 0; c < 16; c++) begin
            chk("cont_acks", {30'd0, i_ack, d_ack},
                {30'd0, (c == 7 || c == 15), (c == 3 || c == 11)});
            tick();
        end
        i_req = 1'b0; d_req = 1'b0;
        tick(); tick(); tick(); tick();

        // ---------------- LAT=1 build ----------------
        d_req1 = 1'b1; d_we1 = 1'b0; d_addr1 = 32'h20;
        tick();
        chk("lat1_m_en_c1",  {31'd0, m_en1}, 32'd1);
        chk("lat1_dack_c1",  {31'd0, d_ack1}, 32'd0);
        tick();
        chk("lat1_dack_c2",  {31'd0, d_ack1}, 32'd1);
        chk("lat1_m_en_c2",  {31'd0, m_en1}, 32'd0);
        chk("lat1_d_rdata",  d_rdata1, 32'h00000055);
        chk("lat1_i_ack",    {31'd0, i_ack1}, 32'd0);
        d_req1 = 1'b0;
        tick();
        chk("lat1_busy_c3",  {31'd0, busy1}, 32'd0);

        // ---------------- randomized run vs reference model ----------------
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        for (int k = 0; k < 16; k++) ref_mem[k] = mem[k];
        i_pend = 0; d_pend = 0; i_req = 0; d_req = 0;
        rm_last = 1'b0; rm_owner = 1'b0; rm_we = 1'b0; rm_rd = '0;
        rm_grant = -10; rm_ack = -10; rm_free = 0;
        e_ir = '0; e_dr = '0;
        for (int c = 0; c < 400; c++) begin
            chk("rnd_i_ack", {31'd0, i_ack}, {31'd0, (c == rm_ack) && !rm_owner});
            chk("rnd_d_ack", {31'd0, d_ack}, {31'd0, (c == rm_ack) && rm_owner});
            chk("rnd_busy",  {31'd0, busy},  {31'd0, (c > rm_grant) && (c < rm_free)});
            if (c == rm_ack && !rm_we) begin
                if (rm_owner) e_dr = rm_rd;
                else          e_ir = rm_rd;
            end
            chk("rnd_i_rdata", i_rdata, e_ir);
            chk("rnd_d_rdata", d_rdata, e_dr);

            // requesters: drop on ack, maybe present a new transaction
            if (i_ack) i_pend = 1'b0;
            if (d_ack) d_pend = 1'b0;
            if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1'b1;
                i_addr = 32'($urandom_range(0, 15)) << 2;
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend  = 1'b1;
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = 32'($urandom_range(0, 15)) << 2;
                d_wdata = $urandom;
            end
            i_req = i_pend;
            d_req = d_pend;

            // model: one access at a time, LAT+2 cycles each, alternate on conflict
            if (c >= rm_free && (i_req || d_req)) begin
                rm_owner = (i_req && d_req) ? !rm_last : d_req;
                rm_last  = rm_owner;
                rm_grant = c;
                rm_ack   = c + LAT + 1;
                rm_free  = c + LAT + 2;
                if (rm_owner && d_we) begin
                    rm_we = 1'b1;
                    ref_mem[d_addr[5:2]] = d_wdata;
                end else begin
                    rm_we = 1'b0;
                    rm_rd = rm_owner ? ref_mem[d_addr[5:2]] : ref_mem[i_addr[5:2]];
                end
            end
            tick();
        end
        i_req = 0; d_req = 0;
        for (int c = 0; c < 6; c++) tick();
        for (int k = 0; k < 16; k++) chk("rnd_mem_final", mem[k], ref_mem[k]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency unified memory between two requesters of the multicycle CPU.
- The instruction-fetch port (IF state) is read-only. The data port (MEM state, lw/sw) does reads and writes.
- The block serialises accesses, counts memory latency, returns read data and pulses a one-cycle acknowledge.
- The CPU control stalls its current state until it sees the acknowledge.

Parameters:
- AW, 32, address width
- DW, 32, data width
- LAT, 2, memory access latency in cycles (LAT >= 1); m_rdata is valid in the LAT-th cycle of the access

Ports:
- CLK  in  1  clock; all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- i_req  in  1  instruction read request; held until i_ack
- i_addr  in  AW  instruction address; stable while i_req is high
- i_ack  out  1  one-cycle pulse, instruction access complete
- i_rdata  out  DW  registered instruction word; valid from i_ack onward
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = write, 0 = read; stable while d_req is high
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_ack  out  1  one-cycle pulse, data access complete
- d_rdata  out  DW  registered load data; valid from d_ack onward
- m_en  out  1  memory enable
- m_we  out  1  memory write enable
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_rdata  in  DW  memory read data
- busy  out  1  high when state is not IDLE

Behaviour:
- Reset values: state = IDLE, counter = 0, last_grant = I. Outputs i_ack, d_ack, m_en, m_we, busy are all 0. i_rdata, d_rdata, m_addr, m_wdata are all 0.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant the port opposite to last_grant. After reset the first conflict therefore goes to D.
  - On grant: latch the granted port's addr into m_addr. For D, also latch d_we and d_wdata. For I, force we = 0.
  - On grant: set last_grant = granted port, load counter = LAT-1, go to ACCESS.
- ACCESS:
  - m_en = 1. m_we = latched we. m_addr and m_wdata come from the latched registers and hold for all LAT cycles.
  - When counter = 0: on a read, capture m_rdata into the granted port's rdata register; go to RESP.
  - Otherwise decrement counter.
- RESP:
  - m_en = 0, m_we = 0. The granted port's ack = 1 for exactly this cycle. Go to IDLE.
- Outside ACCESS, m_en and m_we are 0. m_addr and m_wdata hold their last latched values.
- Latency: request sampled in IDLE at cycle 0, ACCESS covers cycles 1..LAT, ack in cycle LAT+1. Throughput is one access per LAT+2 cycles.
- Requester rule: drop req (or present a new transaction) on the edge where ack = 1 is sampled. A req still high in the following IDLE cycle is treated as a new request.
- Writes: d_rdata is unchanged and d_ack still pulses. The I port never writes.
- The rdata register of the non-granted port never changes.
- Request lines are ignored outside IDLE. Any change to addr/data during ACCESS has no effect.
- Reset in any state (including mid-ACCESS): the in-flight access is abandoned with no ack. Next cycle all reset values apply.
- No transaction is lost or duplicated. Under continuous contention, grants strictly alternate.

Test Plan:
- Reset, then i_req with i_addr = 0x00000004, memory returns 0x8C010008, LAT = 2 -> m_en high cycles 1–2 with m_we = 0, i_ack in cycle 3 only, i_rdata = 0x8C010008, d_ack stays 0.
- d_req, d_we = 1, d_addr = 0x10, d_wdata = 0xDEADBEEF -> m_we = 1 and m_wdata = 0xDEADBEEF for 2 cycles, d_ack in cycle 3, mem[0x10] = 0xDEADBEEF, d_rdata stays 0.
- i_req and d_req both rise together in the first cycle after reset, both held -> D served first (d_ack cycle 3), I served next (i_ack cycle 7), m_addr follows d_addr then i_addr.
- Both requests held high continuously for 16 cycles -> acks alternate D, I, D, I, one every 4 cycles, no port acked twice in a row.
- Reset asserted in the first ACCESS cycle of an I read -> no i_ack. Next cycle: busy = 0, m_en = 0, i_rdata = 0. A new d_req then completes normally 3 cycles after being sampled.
- LAT = 1 build, d read of 0x20 returning 0x00000055 -> m_en high for 1 cycle, d_ack in cycle 2, d_rdata = 0x00000055.
